final_project_platform_led_out: RTL and testbench

Avalon-MM slave output PIO that drives board LEDs and other status lines from the NIOS II, the write-side counterpart of the key input PIO. It holds a software-written output register with atomic bit set/clear, a self-clearing timed pulse mask, and an optional hardware blink mask. It sits on the platform's Avalon bus next to the other PIOs and presents a registered `out_port` to the top level.

---
 rtl/final_project_platform_led_out.sv | 170 +++++++++++++++++
 tb/tb_final_project_platform_led_out.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/final_project_platform_led_out.sv
// ---------------------------------------------------------------------------
// final_project_platform_led_out
//
// Avalon-MM slave output PIO that drives board LEDs and status lines from the
// NIOS II. Holds a software-written data register with atomic bit set/clear,
// a self-clearing timed pulse mask, and an optional hardware blink mask.
//
// Register map (address):
//   0 data     RW  data register
//   1,2        reserved, read 0, writes ignored
//   3 pulse    RW  write ORs bits into the pulse mask and restarts the timer
//   4 outset   W   data |= writedata
//   5 outclear W   data &= ~writedata
//   6 blink    RW  blink mask (only with LED_OUT_BLINK_EN)
//   7 status   R   bit0 = pulse active, bit1 = blink phase
//
// Ports:
//   clk         system clock
//   reset_n     synchronous, active-low reset
//   address     register select (3 bits)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   32-bit write data, bits at and above WIDTH ignored
//   readdata    registered read data, zero-extended, 1-cycle latency
//   out_port    registered output port, WIDTH bits
//
// Optional feature macro: LED_OUT_BLINK_EN
//   defined   -> blink counter, phase and register 6 are built
//   undefined -> no blink logic, register 6 and status bit1 read 0
// ---------------------------------------------------------------------------
module final_project_platform_led_out #(
  parameter int               WIDTH             = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE       = '0,
  parameter int               PULSE_CYCLES      = 1000,
  parameter int               BLINK_HALF_PERIOD = 25000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_PULSE  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;
  localparam logic [2:0] ADDR_BLINK  = 3'd6;
  localparam logic [2:0] ADDR_STATUS = 3'd7;

  localparam logic [31:0] PULSE_RELOAD = 32'(PULSE_CYCLES - 1);

  logic             w_wrEn;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_blinkMask;
  logic             w_phase;
  logic [31:0]      w_readNext;
  logic [WIDTH-1:0] w_outNext;
  logic             w_unusedBits;

  logic [WIDTH-1:0] r_dataReg;
  logic [WIDTH-1:0] r_pulseMask;
  logic [31:0]      r_pcnt;

  assign w_wrEn = chipselect & ~write_n;
  assign w_wd   = writedata[WIDTH-1:0];

  // Data register: plain write, atomic set and atomic clear share one
  // register; the bus allows only one of them per cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_dataReg <= RESET_VALUE;
    end else if (w_wrEn) begin
      case (address)
        ADDR_DATA:   r_dataReg <= w_wd;
        ADDR_OUTSET: r_dataReg <= r_dataReg | w_wd;
        ADDR_OUTCLR: r_dataReg <= r_dataReg & ~w_wd;
        default:     r_dataReg <= r_dataReg;
      endcase
    end
  end

  // Pulse engine: one shared down-counter for all pulse bits. A new pulse
  // write ORs in its bits and restarts the full length for every active bit.
  // The mask clears on the edge where the counter is already zero, which
  // makes the pulse exactly PULSE_CYCLES wide on out_port.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pulseMask <= '0;
      r_pcnt      <= '0;
    end else if (w_wrEn && (address == ADDR_PULSE)) begin
      r_pulseMask <= r_pulseMask | w_wd;
      r_pcnt      <= PULSE_RELOAD;
    end else if (r_pulseMask != '0) begin
      if (r_pcnt == '0) begin
        r_pulseMask <= '0;
      end else begin
        r_pcnt <= r_pcnt - 32'd1;
      end
    end
  end

`ifdef LED_OUT_BLINK_EN
  localparam logic [31:0] BLINK_RELOAD = 32'(BLINK_HALF_PERIOD - 1);

  logic [WIDTH-1:0] r_blinkMask;
  logic [31:0]      r_bcnt;
  logic             r_phase;

  // Blink engine: free-running half-period counter toggling the phase.
  // Writing the mask never touches the counter or phase, so all blinking
  // bits stay in step with each other.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_blinkMask <= '0;
      r_bcnt      <= BLINK_RELOAD;
      r_phase     <= 1'b0;
    end else begin
      if (w_wrEn && (address == ADDR_BLINK)) begin
        r_blinkMask <= w_wd;
      end
      if (r_bcnt == '0) begin
        r_phase <= ~r_phase;
        r_bcnt  <= BLINK_RELOAD;
      end else begin
        r_bcnt <= r_bcnt - 32'd1;
      end
    end
  end

  assign w_blinkMask  = r_blinkMask;
  assign w_phase      = r_phase;
  assign w_unusedBits = ^{1'b0, writedata};
`else
  assign w_blinkMask  = '0;
  assign w_phase      = 1'b0;
  assign w_unusedBits = ^{1'b0, writedata, 32'(BLINK_HALF_PERIOD)};
`endif

  // Read mux works from the current (pre-write) register state so a read
  // on the same edge as a write returns the old value.
  always_comb begin
    w_readNext = '0;
    case (address)
      ADDR_DATA:   w_readNext = 32'(r_dataReg);
      ADDR_PULSE:  w_readNext = 32'(r_pulseMask);
      ADDR_BLINK:  w_readNext = 32'(w_blinkMask);
      ADDR_STATUS: w_readNext = {30'd0, w_phase, (r_pulseMask != '0)};
      default:     w_readNext = '0;
    endcase
  end

  assign w_outNext = (r_dataReg | r_pulseMask) ^ (w_blinkMask & {WIDTH{w_phase}});

  // Registered bus and pin outputs; out_port lags the register state by one
  // edge so a write shows on the pins the cycle after it is accepted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= '0;
      out_port <= RESET_VALUE;
    end else begin
      readdata <= w_readNext;
      out_port <= w_outNext;
    end
  end

endmodule

// File: tb/tb_final_project_platform_led_out.sv
// ---------------------------------------------------------------------------
// tb_final_project_platform_led_out
//
// Self-checking bench for final_project_platform_led_out. A behavioural model
// tracks data, pulse mask (as an absolute expiry edge number) and blink phase
// (as arithmetic on edges since reset); a compare process checks out_port and
// readdata on every falling edge. Directed sequences add literal checks.
// ---------------------------------------------------------------------------
module tb_final_project_platform_led_out;

  localparam int         P  = 4;
  localparam int         H  = 3;
  localparam logic [7:0] RV = 8'h00;
`ifdef LED_OUT_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int vectors     = 0;
  int miscompares = 0;

  final_project_platform_led_out #(
    .WIDTH(8),
    .RESET_VALUE(RV),
    .PULSE_CYCLES(P),
    .BLINK_HALF_PERIOD(H)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0]  mData;
  logic [7:0]  mPulse;
  logic [7:0]  mBlink;
  int          edgeNo     = 0;
  int          clearAt    = 0;
  int          sinceReset = 0;
  bit          modelValid = 1'b0;
  logic [7:0]  expOut;
  logic [31:0] expRd;

  function automatic logic [31:0] modelRead(input logic [2:0] a, input logic ph,
                                            input logic [7:0] d, input logic [7:0] pm,
                                            input logic [7:0] bm);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      3'd0: r = {24'd0, d};
      3'd3: r = {24'd0, pm};
      3'd6: r = BLINK_EN ? {24'd0, bm} : 32'd0;
      3'd7: r = {30'd0, ph, (pm != 8'd0)};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Model update on each rising edge, using the inputs the DUT samples.
  always @(posedge clk) begin
    logic       ph;
    logic       wr;
    logic [7:0] wd;
    edgeNo++;
    if (!reset_n) begin
      mData      = RV;
      mPulse     = 8'd0;
      mBlink     = 8'd0;
      sinceReset = 0;
      expOut     = RV;
      expRd      = 32'd0;
      modelValid = 1'b1;
    end else begin
      ph = BLINK_EN ? (((sinceReset / H) % 2) == 1) : 1'b0;
      sinceReset++;
      expOut = (mData | mPulse) ^ (ph ? mBlink : 8'h00);
      expRd  = modelRead(address, ph, mData, mPulse, mBlink);
      wr = chipselect && !write_n;
      wd = writedata[7:0];
      if (wr && address == 3'd3) begin
        mPulse  = mPulse | wd;
        clearAt = edgeNo + P;
      end else if (mPulse != 8'd0 && edgeNo == clearAt) begin
        mPulse = 8'd0;
      end
      if (wr) begin
        case (address)
          3'd0: mData = wd;
          3'd4: mData = mData | wd;
          3'd5: mData = mData & ~wd;
          3'd6: if (BLINK_EN) mBlink = wd;
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (modelValid) begin
      vectors++;
      if (out_port !== expOut) begin
        miscompares++;
        $display("[TB] FAIL out_port model: got %h expected %h at t=%0t", out_port, expOut, $time);
      end
      vectors++;
      if (readdata !== expRd) begin
        miscompares++;
        $display("[TB] FAIL readdata model: got %h expected %h at t=%0t", readdata, expRd, $time);
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] a, input logic cs, input logic wn,
                               input logic [31:0] wd, input logic rn);
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    reset_n    = rn;
    @(posedge clk);
    #2;
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [31:0] wd);
    applyStimulus(a, 1'b1, 1'b0, wd, 1'b1);
  endtask

  task automatic idle(input logic [2:0] a);
    applyStimulus(a, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  logic [7:0] samples [15];

  initial begin
    int hi0;
    int hi1;
    int bad;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;

    applyStimulus(3'd0, 1'b0, 1'b1, 32'd0, 1'b0);
    applyStimulus(3'd0, 1'b0, 1'b1, 32'd0, 1'b0);
    checkOutput("reset out_port", {24'd0, out_port}, 32'h00);
    checkOutput("reset readdata", readdata, 32'h0);

    // Data write, upper bits ignored
    writeReg(3'd0, 32'hFFFF_FF5A);
    idle(3'd0);
    checkOutput("data out_port", {24'd0, out_port}, 32'h5A);
    checkOutput("data readback", readdata, 32'h0000_005A);

    // Atomic set and clear
    writeReg(3'd4, 32'h81);
    idle(3'd4);
    checkOutput("outset out_port", {24'd0, out_port}, 32'hDB);
    checkOutput("outset reads 0", readdata, 32'h0);
    writeReg(3'd5, 32'h18);
    idle(3'd5);
    checkOutput("outclear out_port", {24'd0, out_port}, 32'hC3);
    checkOutput("outclear reads 0", readdata, 32'h0);

    // Single pulse, exactly P cycles on out_port
    writeReg(3'd0, 32'h00);
    writeReg(3'd3, 32'h01);
    hi0 = 0;
    for (int k = 1; k <= 6; k++) begin
      idle(3'd7);
      hi0 += int'(out_port[0]);
      if (k == 2) checkOutput("status during pulse", readdata, 32'h1);
      if (k == 6) checkOutput("status after pulse", readdata, 32'h0);
    end
    checkOutput("pulse width", hi0, P);

    // Re-write during pulse restarts full length for all bits
    writeReg(3'd3, 32'h01);
    hi0 = 0;
    hi1 = 0;
    idle(3'd3);
    hi0 += int'(out_port[0]);
    hi1 += int'(out_port[1]);
    writeReg(3'd3, 32'h02);
    hi0 += int'(out_port[0]);
    hi1 += int'(out_port[1]);
    for (int k = 0; k < 8; k++) begin
      idle(3'd3);
      hi0 += int'(out_port[0]);
      hi1 += int'(out_port[1]);
    end
    checkOutput("rewrite bit0 width", hi0, 6);
    checkOutput("rewrite bit1 width", hi1, 4);

    // Blink mask
    writeReg(3'd0, 32'h0F);
    writeReg(3'd6, 32'hF0);
    for (int i = 0; i < 15; i++) begin
      idle(3'd6);
      samples[i] = out_port;
      if (i == 0) checkOutput("blink readback", readdata, BLINK_EN ? 32'hF0 : 32'h0);
    end
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (BLINK_EN) begin
        if (samples[i] != 8'h0F && samples[i] != 8'hFF) bad++;
        if (i < 12 && samples[i+3] == samples[i]) bad++;
        if (i < 9 && samples[i+6] != samples[i]) bad++;
      end else begin
        if (samples[i] != 8'h0F) bad++;
      end
    end
    checkOutput("blink pattern errors", bad, 0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      logic [2:0] a;
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a = 3'd3;
      applyStimulus(a, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    $urandom, $urandom_range(0, 49) != 0);
    end

    // Reset in the middle of a pulse
    writeReg(3'd0, 32'h3C);
    writeReg(3'd3, 32'h01);
    idle(3'd0);
    applyStimulus(3'd0, 1'b0, 1'b1, 32'd0, 1'b0);
    checkOutput("midreset out_port", {24'd0, out_port}, 32'h00);
    checkOutput("midreset readdata", readdata, 32'h0);
    idle(3'd3);
    checkOutput("midreset pulse_mask", readdata, 32'h0);
    checkOutput("post reset out_port", {24'd0, out_port}, 32'h00);
    idle(3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
